baccarat_sequencer: RTL
=======================

BACCARAT_SEQUENCER -- requirements
Module: baccarat_sequencer

Interface
REQ-001 Parameter: NATURAL_MIN, default 8; minimum two-card score that ends a round as a natural.
REQ-002 Port: slow_clock, input, 1, the single clock; all state changes occur on its rising edge.
REQ-003 Port: resetb, input, 1, reset; asynchronous, active-low.
REQ-004 Port: step, input, 1, advance request; one step per dealt card or restart.
REQ-005 Port: pscore, input, 4, player hand score 0-9 from the external scoring datapath.
REQ-006 Port: dscore, input, 4, dealer hand score 0-9 from the external scoring datapath.
REQ-007 Port: pcard3, input, 4, player third-card rank 1-13 (1=A, 11=J, 12=Q, 13=K).
REQ-008 Port: load_pcard1/2/3 and load_dcard1/2/3, outputs, 1 each, single-cycle capture enables for the six card registers.
REQ-009 Port: clear_hands, output, 1, single-cycle clear of all six card registers.
REQ-010 Port: done, output, 1, round complete.
REQ-011 Port: player_win_light and dealer_win_light, outputs, 1 each, result lights.

Function
REQ-012 States: DEAL_P1, DEAL_D1, DEAL_P2, DEAL_D2, EVAL1, DEAL_P3, EVAL2, DEAL_D3, DONE.
REQ-013 In each DEAL_x state, load_x = step (Mealy); on step, advance to the next state in the same edge; with step=0, hold the state with all loads at 0.
REQ-014 Deal order: DEAL_P1 -> DEAL_D1 -> DEAL_P2 -> DEAL_D2 -> EVAL1.
REQ-015 EVAL1 lasts exactly one cycle and ignores step; scores read there reflect all four loaded cards.
REQ-016 EVAL1 transitions:
- pscore>=NATURAL_MIN or dscore>=NATURAL_MIN -> DONE
- else pscore<=5 -> DEAL_P3
- else dscore<=5 -> DEAL_D3
- else -> DONE
REQ-017 DEAL_P3 transitions to EVAL2 on step; EVAL2 lasts one cycle, ignores step, and goes to DEAL_D3 if the dealer-draw rule holds, else to DONE.
REQ-018 Dealer-draw rule uses v = (pcard3>=10) ? 0 : pcard3:
- dscore 0-2: draw
- dscore 3: draw if v!=8
- dscore 4: draw if v in 2-7
- dscore 5: draw if v in 4-7
- dscore 6: draw if v in 6-7
- dscore 7: stand
REQ-019 DEAL_D3 transitions to DONE on step.
REQ-020 In DONE:
- done=1
- player_win_light=(pscore>dscore)|(pscore==dscore)
- dealer_win_light=(dscore>pscore)|(pscore==dscore)
- both lights are 0 in every other state
REQ-021 In DONE, step asserts clear_hands for that cycle and moves to DEAL_P1; the lights drop on the next cycle.
REQ-022 At most one load_x or clear_hands is high in any cycle; illegal or unreachable state encodings recover to DEAL_P1 with all outputs 0.
REQ-023 Reachable state values are never out of range, so no score wrap-around arithmetic is needed; comparisons are unsigned 4-bit.

Reset
REQ-024 resetb=0 forces DEAL_P1 immediately, independent of slow_clock, including mid-round.
REQ-025 During reset, all outputs (loads, clear_hands, done, lights) are 0; card-register clearing belongs to the datapath's own reset.
REQ-026 The first step after resetb deasserts produces load_pcard1.

Structure
REQ-027 Package baccarat_pkg holds:
- state enum type
- card rank constants (ACE=1, TEN=10, KING=13)
- the player-draw threshold (5)
REQ-028 The dealer-draw rule (REQ-018) is a combinational sub-module banker_draw_rule (inputs dscore and pcard3; output draw).

Verification
REQ-029 Naturals: 4 steps, then pscore=8, dscore=3 at EVAL1 -> DONE in the next cycle; player light only; no load_pcard3.
REQ-030 Player stands, dealer draws: 4 steps, then pscore=6, dscore=4 -> DEAL_D3; step -> load_dcard3 pulse -> DONE.
REQ-031 Third-card rule: pscore=2, dscore=6 -> DEAL_P3; step with pcard3=7 -> DEAL_D3. Repeat with pcard3=12 -> DONE with no dealer draw.
REQ-032 Tie: DONE with pscore=dscore=5 -> both lights 1. Then step -> clear_hands pulse and state DEAL_P1.
REQ-033 Reset mid-round: drop resetb in DEAL_P3 with no clock edge -> all outputs 0 at once; release, then step -> load_pcard1.
REQ-034 Hold and EVAL behaviour:
- step=0 for 10 cycles in any DEAL state -> no loads and no state change
- step held at 1 through EVAL1 -> EVAL1 still lasts exactly 1 cycle

Source files
------------

// File: rtl/baccarat_pkg.sv
// Shared types and constants for the baccarat round sequencer.
// Card ranks are 1-13; tens and faces count as zero.
package baccarat_pkg;

    typedef enum logic [3:0] {
        ST_DEAL_P1 = 4'd0,
        ST_DEAL_D1 = 4'd1,
        ST_DEAL_P2 = 4'd2,
        ST_DEAL_D2 = 4'd3,
        ST_EVAL1   = 4'd4,
        ST_DEAL_P3 = 4'd5,
        ST_EVAL2   = 4'd6,
        ST_DEAL_D3 = 4'd7,
        ST_DONE    = 4'd8
    } state_t;

    localparam logic [3:0] ACE  = 4'd1;
    localparam logic [3:0] TEN  = 4'd10;
    localparam logic [3:0] KING = 4'd13;

    // Highest two-card score at which the player (or a standing-player dealer) draws.
    localparam logic [3:0] PLAYER_DRAW_MAX = 4'd5;

    function automatic logic [3:0] card_value(input logic [3:0] rank);
        return (rank >= TEN) ? 4'd0 : rank;
    endfunction

endpackage

// File: rtl/banker_draw_rule.sv
// Dealer third-card decision once the player has drawn a third card.
// Purely combinational: depends on dealer score and player's third-card rank.
module banker_draw_rule
    import baccarat_pkg::*;
(
    input  logic [3:0] dscore,
    input  logic [3:0] pcard3,
    output logic       draw
);

    logic [3:0] w_v;

    assign w_v = card_value(pcard3);

    always_comb begin
        draw = 1'b0;
        case (dscore)
            4'd0, 4'd1, 4'd2: draw = 1'b1;
            4'd3:             draw = (w_v != 4'd8);
            4'd4:             draw = (w_v >= 4'd2) && (w_v <= 4'd7);
            4'd5:             draw = (w_v >= 4'd4) && (w_v <= 4'd7);
            4'd6:             draw = (w_v >= 4'd6) && (w_v <= 4'd7);
            default:          draw = 1'b0;
        endcase
    end

endmodule

// File: rtl/baccarat_sequencer.sv
// Round sequencer for baccarat: deals four cards, applies the third-card rules,
// and shows the result until the next step clears the hands.
module baccarat_sequencer
    import baccarat_pkg::*;
#(
    parameter int unsigned NATURAL_MIN = 8
) (
    input  logic       slow_clock,
    input  logic       resetb,
    input  logic       step,
    input  logic [3:0] pscore,
    input  logic [3:0] dscore,
    input  logic [3:0] pcard3,
    output logic       load_pcard1,
    output logic       load_pcard2,
    output logic       load_pcard3,
    output logic       load_dcard1,
    output logic       load_dcard2,
    output logic       load_dcard3,
    output logic       clear_hands,
    output logic       done,
    output logic       player_win_light,
    output logic       dealer_win_light
);

    localparam logic [3:0] NAT_MIN = 4'(NATURAL_MIN);

    state_t r_state;
    state_t w_next;

    logic w_dealer_draw;
    logic w_natural;
    logic w_lp1, w_lp2, w_lp3, w_ld1, w_ld2, w_ld3;
    logic w_clear, w_done, w_pwin, w_dwin;

    banker_draw_rule u_banker_draw_rule (
        .dscore (dscore),
        .pcard3 (pcard3),
        .draw   (w_dealer_draw)
    );

    assign w_natural = (pscore >= NAT_MIN) || (dscore >= NAT_MIN);

    always_ff @(posedge slow_clock or negedge resetb) begin
        if (!resetb) begin
            r_state <= ST_DEAL_P1;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next  = r_state;
        w_lp1   = 1'b0;
        w_lp2   = 1'b0;
        w_lp3   = 1'b0;
        w_ld1   = 1'b0;
        w_ld2   = 1'b0;
        w_ld3   = 1'b0;
        w_clear = 1'b0;
        w_done  = 1'b0;
        w_pwin  = 1'b0;
        w_dwin  = 1'b0;
        case (r_state)
            ST_DEAL_P1: begin
                w_lp1 = step;
                if (step) w_next = ST_DEAL_D1;
            end
            ST_DEAL_D1: begin
                w_ld1 = step;
                if (step) w_next = ST_DEAL_P2;
            end
            ST_DEAL_P2: begin
                w_lp2 = step;
                if (step) w_next = ST_DEAL_D2;
            end
            ST_DEAL_D2: begin
                w_ld2 = step;
                if (step) w_next = ST_EVAL1;
            end
            ST_EVAL1: begin
                if (w_natural)                       w_next = ST_DONE;
                else if (pscore <= PLAYER_DRAW_MAX)  w_next = ST_DEAL_P3;
                else if (dscore <= PLAYER_DRAW_MAX)  w_next = ST_DEAL_D3;
                else                                 w_next = ST_DONE;
            end
            ST_DEAL_P3: begin
                w_lp3 = step;
                if (step) w_next = ST_EVAL2;
            end
            ST_EVAL2: begin
                w_next = w_dealer_draw ? ST_DEAL_D3 : ST_DONE;
            end
            ST_DEAL_D3: begin
                w_ld3 = step;
                if (step) w_next = ST_DONE;
            end
            ST_DONE: begin
                w_done  = 1'b1;
                w_pwin  = (pscore >= dscore);
                w_dwin  = (dscore >= pscore);
                w_clear = step;
                if (step) w_next = ST_DEAL_P1;
            end
            default: begin
                w_next = ST_DEAL_P1;
            end
        endcase
    end

    // Mealy outputs are masked while reset is held so a high step cannot leak a load.
    assign load_pcard1      = resetb & w_lp1;
    assign load_pcard2      = resetb & w_lp2;
    assign load_pcard3      = resetb & w_lp3;
    assign load_dcard1      = resetb & w_ld1;
    assign load_dcard2      = resetb & w_ld2;
    assign load_dcard3      = resetb & w_ld3;
    assign clear_hands      = resetb & w_clear;
    assign done             = resetb & w_done;
    assign player_win_light = resetb & w_pwin;
    assign dealer_win_light = resetb & w_dwin;

endmodule
